// File: rtl/lcd_view_sched.sv
// LCD line-1 view scheduler: TIME/ALARM/RING selection, binary->ASCII fields, edit-field blink,
// char outputs updated only on FRAME_TICK. Define LCD_SCHED_24H_EN for a 24h display (default 12h).
module lcd_view_sched #(
  parameter int TIMEOUT_FRAMES = 64,
  parameter int RING_FRAMES    = 255,
  parameter int BLINK_FRAMES   = 8
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic       FRAME_TICK,
  input  logic [4:0] CUR_HOUR,
  input  logic [5:0] CUR_MIN,
  input  logic [5:0] CUR_SEC,
  input  logic [4:0] ALM_HOUR,
  input  logic [5:0] ALM_MIN,
  input  logic       VIEW_REQ,
  input  logic       ALARM_FIRE,
  input  logic       ALARM_ACK,
  input  logic [1:0] EDIT_FIELD,
  output logic [7:0] H10,
  output logic [7:0] H1,
  output logic [7:0] M10,
  output logic [7:0] M1,
  output logic [7:0] S10,
  output logic [7:0] S1,
  output logic [7:0] MERIDIAN,
  output logic [1:0] VIEW,
  output logic       RING
);

  typedef enum logic [1:0] {
    ST_TIME  = 2'b00,
    ST_ALARM = 2'b01,
    ST_RING  = 2'b10
  } state_t;

  localparam logic [7:0]  CH_SP      = 8'h20;
  localparam logic [7:0]  CH_DASH    = 8'h2D;
  localparam logic [7:0]  CH_A       = 8'h41;
  localparam logic [7:0]  CH_P       = 8'h50;
  localparam logic [15:0] PAIR_SP    = {CH_SP, CH_SP};
  localparam logic [15:0] PAIR_DASH  = {CH_DASH, CH_DASH};
  localparam logic [55:0] RING_TEXT  = "ALARM! ";
  localparam logic [55:0] ALL_SP     = {7{CH_SP}};
  localparam logic [7:0]  TO_LAST    = 8'(TIMEOUT_FRAMES - 1);
  localparam logic [7:0]  RING_LAST  = 8'(RING_FRAMES - 1);
  localparam logic [7:0]  BLINK_LAST = 8'(BLINK_FRAMES - 1);
`ifdef LCD_SCHED_24H_EN
  localparam logic        BLANK_H10  = 1'b0;
`else
  localparam logic        BLANK_H10  = 1'b1;
`endif

  state_t      state;
  state_t      nxt_state;
  logic [7:0]  frame_cnt;
  logic [7:0]  blink_cnt;
  logic        blink_hidden;
  logic [1:0]  edit_q;
  logic        edit_chg;
  logic        hide_now;

  logic [4:0]  hour_src;
  logic [5:0]  min_src;
  logic [4:0]  hr_disp;
  logic [7:0]  mer;
  logic [15:0] h_pair;
  logic [15:0] m_pair;
  logic [15:0] s_pair;
  logic [55:0] nxt_chars;

  function automatic logic [3:0] tens_of(input logic [5:0] v);
    if      (v >= 6'd60) tens_of = 4'd6;
    else if (v >= 6'd50) tens_of = 4'd5;
    else if (v >= 6'd40) tens_of = 4'd4;
    else if (v >= 6'd30) tens_of = 4'd3;
    else if (v >= 6'd20) tens_of = 4'd2;
    else if (v >= 6'd10) tens_of = 4'd1;
    else                 tens_of = 4'd0;
  endfunction

  function automatic logic [15:0] two_dig(input logic [5:0] v, input logic ok, input logic blank_tens);
    logic [3:0] t;
    logic [5:0] u;
    t = tens_of(v);
    u = v - ({2'b00, t} * 6'd10);
    if (!ok)
      two_dig = PAIR_DASH;
    else if (blank_tens && t == 4'd0)
      two_dig = {CH_SP, 8'h30 + {4'h0, u[3:0]}};
    else
      two_dig = {8'h30 + {4'h0, t}, 8'h30 + {4'h0, u[3:0]}};
  endfunction

  always_comb begin
    nxt_state = state;
    case (state)
      ST_TIME: begin
        if (ALARM_FIRE)    nxt_state = ST_RING;
        else if (VIEW_REQ) nxt_state = ST_ALARM;
      end
      ST_ALARM: begin
        if (ALARM_FIRE)                              nxt_state = ST_RING;
        else if (VIEW_REQ)                           nxt_state = ST_TIME;
        else if (FRAME_TICK && frame_cnt == TO_LAST) nxt_state = ST_TIME;
      end
      ST_RING: begin
        if (ALARM_ACK)                                 nxt_state = ST_TIME;
        else if (FRAME_TICK && frame_cnt == RING_LAST) nxt_state = ST_TIME;
      end
      default: nxt_state = ST_TIME;
    endcase
  end

  // Frame counter restarts on every state change so timeouts are measured from entry.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state     <= ST_TIME;
      VIEW      <= 2'b00;
      RING      <= 1'b0;
      frame_cnt <= 8'd0;
    end else begin
      state <= nxt_state;
      VIEW  <= nxt_state;
      RING  <= (nxt_state == ST_RING);
      if (nxt_state != state)
        frame_cnt <= 8'd0;
      else if (FRAME_TICK)
        frame_cnt <= frame_cnt + 8'd1;
    end
  end

  assign edit_chg = (EDIT_FIELD != edit_q);

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      edit_q       <= 2'b00;
      blink_cnt    <= 8'd0;
      blink_hidden <= 1'b0;
    end else begin
      edit_q <= EDIT_FIELD;
      if (edit_chg) begin
        blink_cnt    <= 8'd0;
        blink_hidden <= 1'b0;
      end else if (FRAME_TICK) begin
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt    <= 8'd0;
          blink_hidden <= ~blink_hidden;
        end else begin
          blink_cnt <= blink_cnt + 8'd1;
        end
      end
    end
  end

  // A fresh EDIT_FIELD value is always shown visible, even on the cycle it changes.
  assign hide_now = blink_hidden && !edit_chg;

  always_comb begin
    hour_src = (state == ST_ALARM) ? ALM_HOUR : CUR_HOUR;
    min_src  = (state == ST_ALARM) ? ALM_MIN  : CUR_MIN;
    hr_disp  = hour_src;
    mer      = CH_SP;
`ifndef LCD_SCHED_24H_EN
    if (hour_src == 5'd0)      hr_disp = 5'd12;
    else if (hour_src > 5'd12) hr_disp = hour_src - 5'd12;
    mer = (hour_src < 5'd12) ? CH_A : CH_P;
`endif
    if (hour_src > 5'd23) mer = CH_SP;

    h_pair = two_dig({1'b0, hr_disp}, hour_src <= 5'd23, BLANK_H10);
    m_pair = two_dig(min_src, min_src <= 6'd59, 1'b0);
    s_pair = (state == ST_ALARM) ? PAIR_DASH : two_dig(CUR_SEC, CUR_SEC <= 6'd59, 1'b0);

    if (hide_now) begin
      case (EDIT_FIELD)
        2'b01:   h_pair = PAIR_SP;
        2'b10:   m_pair = PAIR_SP;
        2'b11:   if (state == ST_TIME) s_pair = PAIR_SP;
        default: ;
      endcase
    end

    nxt_chars = {h_pair, m_pair, s_pair, mer};
    if (state == ST_RING)
      nxt_chars = frame_cnt[0] ? ALL_SP : RING_TEXT;
  end

  always_ff @(posedge CLK) begin
    if (!RESETN)
      {H10, H1, M10, M1, S10, S1, MERIDIAN} <= ALL_SP;
    else if (FRAME_TICK)
      {H10, H1, M10, M1, S10, S1, MERIDIAN} <= nxt_chars;
  end

endmodule

// File: tb/tb_lcd_view_sched.sv
// Directed bench for lcd_view_sched (default 12h build): expected frames queued per tick, checked after.
module tb_lcd_view_sched;
  logic       CLK;
  logic       RESETN;
  logic       FRAME_TICK;
  logic [4:0] CUR_HOUR;
  logic [5:0] CUR_MIN;
  logic [5:0] CUR_SEC;
  logic [4:0] ALM_HOUR;
  logic [5:0] ALM_MIN;
  logic       VIEW_REQ;
  logic       ALARM_FIRE;
  logic       ALARM_ACK;
  logic [1:0] EDIT_FIELD;
  logic [7:0] H10, H1, M10, M1, S10, S1, MERIDIAN;
  logic [1:0] VIEW;
  logic       RING;

  localparam logic [55:0] BLANK = {7{8'h20}};

  int errors = 0;
  int checks = 0;
  logic [55:0] sb[$];
  logic [55:0] chars;

  assign chars = {H10, H1, M10, M1, S10, S1, MERIDIAN};

  lcd_view_sched dut (
    .CLK(CLK), .RESETN(RESETN), .FRAME_TICK(FRAME_TICK),
    .CUR_HOUR(CUR_HOUR), .CUR_MIN(CUR_MIN), .CUR_SEC(CUR_SEC),
    .ALM_HOUR(ALM_HOUR), .ALM_MIN(ALM_MIN),
    .VIEW_REQ(VIEW_REQ), .ALARM_FIRE(ALARM_FIRE), .ALARM_ACK(ALARM_ACK),
    .EDIT_FIELD(EDIT_FIELD),
    .H10(H10), .H1(H1), .M10(M10), .M1(M1), .S10(S10), .S1(S1), .MERIDIAN(MERIDIAN),
    .VIEW(VIEW), .RING(RING)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [55:0] obs, input logic [55:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Queue the expected frame, pulse FRAME_TICK for one cycle, then compare away from the edge.
  task automatic do_tick(input string tag, input logic [55:0] exp);
    logic [55:0] e;
    sb.push_back(exp);
    @(negedge CLK) FRAME_TICK = 1'b1;
    @(negedge CLK) FRAME_TICK = 1'b0;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed=empty_scoreboard expected=entry", tag);
    end else begin
      e = sb.pop_front();
      chk(tag, chars, e);
    end
  endtask

  // which: 0 VIEW_REQ, 1 ALARM_FIRE, 2 ALARM_ACK
  task automatic pulse(input int which);
    @(negedge CLK);
    case (which)
      0: VIEW_REQ = 1'b1;
      1: ALARM_FIRE = 1'b1;
      default: ALARM_ACK = 1'b1;
    endcase
    @(negedge CLK);
    VIEW_REQ = 1'b0;
    ALARM_FIRE = 1'b0;
    ALARM_ACK = 1'b0;
  endtask

  initial begin
    RESETN = 1'b0; FRAME_TICK = 1'b0;
    CUR_HOUR = 5'd13; CUR_MIN = 6'd5; CUR_SEC = 6'd9;
    ALM_HOUR = 5'd7; ALM_MIN = 6'd30;
    VIEW_REQ = 1'b0; ALARM_FIRE = 1'b0; ALARM_ACK = 1'b0; EDIT_FIELD = 2'b00;
    repeat (3) @(negedge CLK);
    chk("reset_chars", chars, BLANK);
    chk("reset_view", {54'd0, VIEW}, 56'd0);
    chk("reset_ring", {55'd0, RING}, 56'd0);
    RESETN = 1'b1;

    // Basic conversion and tick-only update
    do_tick("time_13", " 10509P");
    chk("time_view", {54'd0, VIEW}, 56'd0);
    CUR_SEC = 6'd10;
    repeat (3) @(negedge CLK);
    chk("no_tick_hold", chars, " 10509P");
    CUR_SEC = 6'd9;

    // Hour boundaries and out-of-range fields
    CUR_HOUR = 5'd0;  do_tick("hour_0",  "120509A");
    CUR_HOUR = 5'd11; do_tick("hour_11", "110509A");
    CUR_HOUR = 5'd12; do_tick("hour_12", "120509P");
    CUR_HOUR = 5'd23; do_tick("hour_23", "110509P");
    CUR_HOUR = 5'd24; do_tick("hour_24", "--0509 ");
    CUR_HOUR = 5'd13; CUR_MIN = 6'd60; do_tick("min_60", " 1--09P");
    CUR_MIN = 6'd5; CUR_SEC = 6'd63; do_tick("sec_63", " 105--P");
    CUR_SEC = 6'd9;

    // ALARM view and its timeout
    pulse(0);
    chk("alarm_view", {54'd0, VIEW}, 56'd1);
    for (int i = 0; i < 63; i++) do_tick("alarm_frame", " 730--A");
    chk("alarm_before_timeout", {54'd0, VIEW}, 56'd1);
    do_tick("alarm_last", " 730--A");
    chk("alarm_timeout", {54'd0, VIEW}, 56'd0);
    do_tick("back_to_time", " 10509P");
    pulse(0);
    chk("view_req_to_alarm", {54'd0, VIEW}, 56'd1);
    pulse(0);
    chk("view_req_to_time", {54'd0, VIEW}, 56'd0);
    pulse(2);
    chk("ack_ignored_time", {54'd0, VIEW}, 56'd0);

    // RING priority, flashing, acknowledge
    @(negedge CLK); ALARM_FIRE = 1'b1; VIEW_REQ = 1'b1;
    @(negedge CLK); ALARM_FIRE = 1'b0; VIEW_REQ = 1'b0;
    chk("fire_prio_view", {54'd0, VIEW}, 56'd2);
    chk("fire_prio_ring", {55'd0, RING}, 56'd1);
    do_tick("ring_f0", "ALARM! ");
    do_tick("ring_f1", BLANK);
    do_tick("ring_f2", "ALARM! ");
    pulse(0);
    chk("view_req_in_ring", {54'd0, VIEW}, 56'd2);
    do_tick("ring_f3", BLANK);
    pulse(2);
    chk("ack_view", {54'd0, VIEW}, 56'd0);
    chk("ack_ring", {55'd0, RING}, 56'd0);
    do_tick("after_ack", " 10509P");

    // RING timeout without acknowledge
    pulse(1);
    for (int i = 0; i < 254; i++) begin
      if (i == 100) pulse(0);
      do_tick("ring_long", (i % 2 == 1) ? BLANK : 56'("ALARM! "));
    end
    chk("ring_before_timeout", {54'd0, VIEW}, 56'd2);
    do_tick("ring_last", "ALARM! ");
    chk("ring_timeout", {54'd0, VIEW}, 56'd0);

    // Blink of the minute field, then switch to hour
    @(negedge CLK) EDIT_FIELD = 2'b10;
    repeat (2) @(negedge CLK);
    for (int i = 0; i < 8; i++) do_tick("blink_vis1", " 10509P");
    for (int i = 0; i < 8; i++) do_tick("blink_hid1", " 1  09P");
    for (int i = 0; i < 8; i++) do_tick("blink_vis2", " 10509P");
    do_tick("blink_hid2", " 1  09P");
    @(negedge CLK) EDIT_FIELD = 2'b01;
    for (int i = 0; i < 8; i++) do_tick("hour_edit_vis", " 10509P");
    do_tick("hour_edit_hid", "  0509P");

    // Reset in the middle of RING
    @(negedge CLK) EDIT_FIELD = 2'b00;
    pulse(1);
    do_tick("ring_pre_reset", "ALARM! ");
    @(negedge CLK) RESETN = 1'b0;
    @(negedge CLK) RESETN = 1'b1;
    chk("midreset_chars", chars, BLANK);
    chk("midreset_view", {54'd0, VIEW}, 56'd0);
    chk("midreset_ring", {55'd0, RING}, 56'd0);
    do_tick("post_reset", " 10509P");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
